irrigation_timer: RTL
=====================

Name: irrigation_timer

Overview:
- Times each irrigation cycle. Sits between the irrigation controller/selector and the valve gating and 7-segment path.
- Loads a mode-dependent duration when irrigation is requested, then counts down as BCD MM:SS on a one-cycle tick enable.
- Holds its count while a water-sensor conflict is flagged and signals completion.
- Its outputs gate the sprinkler pump and dripper valve, and supply the minute/second digits to the display driver.

Parameters:
- SPLINKER_MINUTES, 15, sprinkler-mode cycle length in whole minutes; legal range 1..39.
- DRIPPER_MINUTES, 30, dripper-mode cycle length in whole minutes; legal range 1..39.

Ports:
- clock  input  1  system clock
- reset_n  input  1  synchronous active-low reset
- tick  input  1  one-clock-wide 1 Hz enable from the clock-divider chain
- irrigation_on  input  1  irrigation prerequisites met (level, treated as request)
- splinker_mode_on  input  1  1 = sprinkler mode, 0 = dripper mode
- conflicting_values  input  1  water-sensor error flag
- timer_active  output  1  high only in RUN; ANDed with the mode outputs to drive the valves
- timer_done  output  1  one-cycle pulse on expiry
- latched_mode  output  1  mode captured at load
- minutes_d  output  2  BCD minutes tens, 0..3
- minutes_u  output  4  BCD minutes units, 0..9
- seconds_d  output  3  BCD seconds tens, 0..5
- seconds_u  output  4  BCD seconds units, 0..9

Behaviour:
- Interface: one clock (clock); reset is synchronous and active-low (reset_n). All state changes on the rising edge of clock.
- Reset, when reset_n=0 at an edge:
  - state=IDLE
  - all digits 0
  - timer_active=0, timer_done=0, latched_mode=0
  - internal irrigation_on history register=0
- Reset overrides every other input, including in mid-count.
- States:
  - IDLE -> RUN on a rising edge of irrigation_on (previous 0, current 1) with conflicting_values=0.
    - Loads minutes from the selected parameter (tens and units split), seconds 00.
    - Latches splinker_mode_on into latched_mode.
    - timer_active goes high on the cycle after the edge is sampled (latency 1).
  - RUN:
    - A tick decrements the count by 1 s. A tick in the load cycle itself is ignored.
    - Borrow chain: seconds_u 0->9 borrows from seconds_d; seconds_d 0->5 borrows from minutes_u; minutes_u 0->9 borrows from minutes_d.
    - A tick at 00:01 -> 00:00: go to DONE, timer_done=1 for exactly one cycle, timer_active=0 that same cycle.
  - RUN -> HOLD when conflicting_values=1. Count frozen, timer_active=0, ticks ignored.
  - HOLD:
    - -> RUN when conflicting_values=0 and irrigation_on=1. Resumes from the frozen count with no reload.
    - -> IDLE when irrigation_on=0, regardless of conflicting_values.
  - RUN -> IDLE when irrigation_on=0. Digits clear to 00:00 and no timer_done is issued.
  - DONE: digits stay 00:00. Stays in DONE while irrigation_on=1; a new cycle needs irrigation_on to go low (-> IDLE) and then rise again.
- Simultaneous events in RUN, priority: irrigation_on=0 > conflicting_values=1 > tick.
- A tick arriving while entering HOLD does not decrement.
- splinker_mode_on changes after load are ignored until the next load.
- A rising edge of irrigation_on while conflicting_values=1 is not a start. Stay in IDLE until a fresh rising edge.
- Digits never leave legal BCD ranges. The count never decrements below 00:00.

Decomposition:
- Shared package irrigation_pkg:
  - state encoding IDLE/RUN/HOLD/DONE (2 bits)
  - digit width constants (2/4/3/4)
  - digit max constants (3, 9, 5, 9)
- One natural sub-module, bcd_down_digit, instantiated four times:
  - parameterised width and max value
  - inputs: load, load_value, dec_en
  - outputs: value, borrow_out, asserted when value=0 and dec_en
  - same clock and reset_n

Test Plan:
- Reset mid-run: start in sprinkler mode, apply 100 ticks, pulse reset_n=0 for one cycle -> all outputs 0, state IDLE, a fresh irrigation_on edge is required to restart.
- Sprinkler load and borrow: irrigation_on 0->1 with splinker_mode_on=1 -> next cycle 15:00 and timer_active=1; one tick -> 14:59; 60 further ticks -> 13:59.
- Full expiry: DRIPPER_MINUTES=1, dripper start, 60 ticks -> 00:00, timer_done pulses exactly 1 cycle, timer_active=0; extra ticks leave 00:00; drop and re-raise irrigation_on -> reloads 01:00.
- Conflict hold: at 10:05 raise conflicting_values for 5 ticks -> count stays 10:05, timer_active=0; clear it -> next tick 10:04; repeat with irrigation_on dropped during HOLD -> IDLE, 00:00.
- Priority and mode latch: in RUN, assert tick, conflicting_values=1 and irrigation_on=0 in the same cycle -> IDLE, 00:00, no timer_done; in a new run, toggle splinker_mode_on -> latched_mode is unchanged.
- Blocked start: irrigation_on rises while conflicting_values=1 -> stays IDLE; clear the conflict with irrigation_on held high -> still IDLE.

Source files
------------

// File: rtl/irrigation_pkg.sv
// irrigation_pkg: shared state encoding and BCD digit widths/limits for the irrigation timer
package irrigation_pkg;
  typedef enum logic [1:0] {IDLE, RUN, HOLD, DONE} state_e;
  localparam int MD_W = 2;
  localparam int MU_W = 4;
  localparam int SD_W = 3;
  localparam int SU_W = 4;
  localparam int MD_MAX = 3;
  localparam int MU_MAX = 9;
  localparam int SD_MAX = 5;
  localparam int SU_MAX = 9;
endpackage

// File: rtl/irrigation_timer_if.sv
// irrigation_timer_if: controller-side request/status bundle of the irrigation timer
//   master: drives tick, irrigation_on, splinker_mode_on, conflicting_values; reads status and digits
//   slave : the timer, the reverse directions
interface irrigation_timer_if;
  import irrigation_pkg::*;
  logic tick;
  logic irrigation_on;
  logic splinker_mode_on;
  logic conflicting_values;
  logic timer_active;
  logic timer_done;
  logic latched_mode;
  logic [MD_W-1:0] minutes_d;
  logic [MU_W-1:0] minutes_u;
  logic [SD_W-1:0] seconds_d;
  logic [SU_W-1:0] seconds_u;
  modport master (
    output tick, irrigation_on, splinker_mode_on, conflicting_values,
    input  timer_active, timer_done, latched_mode, minutes_d, minutes_u, seconds_d, seconds_u
  );
  modport slave (
    input  tick, irrigation_on, splinker_mode_on, conflicting_values,
    output timer_active, timer_done, latched_mode, minutes_d, minutes_u, seconds_d, seconds_u
  );
endinterface

// File: rtl/bcd_down_digit.sv
// bcd_down_digit: one loadable BCD down-counting digit wrapping 0 -> MAX with a borrow out
//   clock, reset_n : clock, synchronous active-low reset (clears to 0)
//   i_load/i_load_value : load takes priority over decrement
//   i_dec_en       : decrement by one
//   o_value, o_borrow_out : current digit; borrow when decrementing through 0
module bcd_down_digit #(
  parameter int W = 4,
  parameter int MAX = 9
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         i_load,
  input  logic [W-1:0] i_load_value,
  input  logic         i_dec_en,
  output logic [W-1:0] o_value,
  output logic         o_borrow_out
);
  logic [W-1:0] r_value;
  always_ff @(posedge clock) begin
    if (!reset_n) r_value <= '0;
    else if (i_load) r_value <= i_load_value;
    else if (i_dec_en) r_value <= (r_value == '0) ? W'(MAX) : r_value - W'(1);
  end
  assign o_value = r_value;
  assign o_borrow_out = i_dec_en && (r_value == '0);
endmodule

// File: rtl/irrigation_timer.sv
// irrigation_timer: loads a mode-dependent MM:SS duration on an irrigation request and counts it down on ticks
//   clock, reset_n : clock, synchronous active-low reset
//   bus (slave)    : tick/irrigation_on/splinker_mode_on/conflicting_values in;
//                    timer_active/timer_done/latched_mode and BCD MM:SS digits out
module irrigation_timer
  import irrigation_pkg::*;
#(
  parameter int SPLINKER_MINUTES = 15,
  parameter int DRIPPER_MINUTES = 30
) (
  input  logic clock,
  input  logic reset_n,
  irrigation_timer_if.slave bus
);
  localparam logic [MD_W-1:0] SPL_T = MD_W'(SPLINKER_MINUTES / 10);
  localparam logic [MU_W-1:0] SPL_U = MU_W'(SPLINKER_MINUTES % 10);
  localparam logic [MD_W-1:0] DRP_T = MD_W'(DRIPPER_MINUTES / 10);
  localparam logic [MU_W-1:0] DRP_U = MU_W'(DRIPPER_MINUTES % 10);
  state_e r_state, w_next;
  logic r_irr_prev, r_mode, r_done;
  logic w_rise, w_load, w_clear, w_dec, w_expire, w_last, w_digit_load;
  logic w_bsu, w_bsd, w_bmu, w_bmd;
  logic [MD_W-1:0] w_md, w_md_load;
  logic [MU_W-1:0] w_mu, w_mu_load;
  logic [SD_W-1:0] w_sd;
  logic [SU_W-1:0] w_su;
  assign w_rise = bus.irrigation_on && !r_irr_prev;
  assign w_last = (w_md == '0) && (w_mu == '0) && (w_sd == '0) && (w_su == SU_W'(1));
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_state <= IDLE;
      r_irr_prev <= 1'b0;
      r_mode <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_state <= w_next;
      r_irr_prev <= bus.irrigation_on;
      r_mode <= w_load ? bus.splinker_mode_on : r_mode;
      r_done <= w_expire;
    end
  end
  // Priority inside RUN: request dropped > sensor conflict > tick.
  always_comb begin
    w_next = r_state;
    w_load = 1'b0;
    w_clear = 1'b0;
    w_dec = 1'b0;
    w_expire = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_rise && !bus.conflicting_values) begin
          w_next = RUN;
          w_load = 1'b1;
        end
      end
      RUN: begin
        if (!bus.irrigation_on) begin
          w_next = IDLE;
          w_clear = 1'b1;
        end else if (bus.conflicting_values) begin
          w_next = HOLD;
        end else if (bus.tick) begin
          w_dec = 1'b1;
          w_next = w_last ? DONE : RUN;
          w_expire = w_last;
        end
      end
      HOLD: begin
        if (!bus.irrigation_on) begin
          w_next = IDLE;
          w_clear = 1'b1;
        end else if (!bus.conflicting_values) begin
          w_next = RUN;
        end
      end
      DONE: w_next = bus.irrigation_on ? DONE : IDLE;
      default: w_next = IDLE;
    endcase
  end
  // A borrow out of the minutes-tens digit would mean wrapping below 00:00; it reloads zeros instead.
  assign w_digit_load = w_load || w_clear || w_bmd;
  assign w_md_load = w_load ? (bus.splinker_mode_on ? SPL_T : DRP_T) : '0;
  assign w_mu_load = w_load ? (bus.splinker_mode_on ? SPL_U : DRP_U) : '0;
  bcd_down_digit #(.W(SU_W), .MAX(SU_MAX)) u_su (
    .clock(clock), .reset_n(reset_n), .i_load(w_digit_load), .i_load_value('0),
    .i_dec_en(w_dec), .o_value(w_su), .o_borrow_out(w_bsu)
  );
  bcd_down_digit #(.W(SD_W), .MAX(SD_MAX)) u_sd (
    .clock(clock), .reset_n(reset_n), .i_load(w_digit_load), .i_load_value('0),
    .i_dec_en(w_bsu), .o_value(w_sd), .o_borrow_out(w_bsd)
  );
  bcd_down_digit #(.W(MU_W), .MAX(MU_MAX)) u_mu (
    .clock(clock), .reset_n(reset_n), .i_load(w_digit_load), .i_load_value(w_mu_load),
    .i_dec_en(w_bsd), .o_value(w_mu), .o_borrow_out(w_bmu)
  );
  bcd_down_digit #(.W(MD_W), .MAX(MD_MAX)) u_md (
    .clock(clock), .reset_n(reset_n), .i_load(w_digit_load), .i_load_value(w_md_load),
    .i_dec_en(w_bmu), .o_value(w_md), .o_borrow_out(w_bmd)
  );
  assign bus.timer_active = (r_state == RUN);
  assign bus.timer_done = r_done;
  assign bus.latched_mode = r_mode;
  assign bus.minutes_d = w_md;
  assign bus.minutes_u = w_mu;
  assign bus.seconds_d = w_sd;
  assign bus.seconds_u = w_su;
endmodule
